// File: rtl/minicpu_pkg.sv
// Shared MiniCPU definitions: bus widths, instruction field slices, sequencer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package minicpu_pkg;

    localparam int INSTR_W  = 12;
    localparam int RESULT_W = 8;

    // Instruction word layout; the sequencer treats both fields as opaque.
    localparam int OPC_MSB  = 11;
    localparam int OPC_LSB  = 8;
    localparam int OPND_MSB = 7;
    localparam int OPND_LSB = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } seq_state_t;

endpackage

// File: rtl/minicpu_seq_ram.sv
// One-write/one-read synchronous RAM with a registered read port.
// Latency: 1 cycle read; a read of the address being written returns the old word.
// Backpressure: none; rclr/rst force the read register to CLR_VAL instead of reading.
module minicpu_seq_ram #(
    parameter int               WIDTH   = 12,
    parameter int               DEPTH   = 16,
    parameter int               ADDR_W  = 4,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              rclr,
    output logic [WIDTH-1:0]  rdata
);

    // Storage is deliberately left out of reset so contents survive a run abort.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rclr) begin
            rdata <= CLR_VAL;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/minicpu_program_sequencer.sv
// Issues a loaded program to the MiniCPU one word per HOLD_CYCLES clocks and buffers results.
// Latency: first word on CPU_IN one cycle after START; DONE at START+1+n*HOLD_CYCLES.
// Backpressure: none; START and PROG_WE are ignored while a run is in progress.
module minicpu_program_sequencer
    import minicpu_pkg::*;
#(
    parameter int                 DEPTH       = 16,
    parameter int                 ADDR_W      = 4,
    parameter int                 HOLD_CYCLES = 3,
    parameter bit                 STOP_ON_OVF = 1'b0,
    parameter logic [INSTR_W-1:0] IDLE_WORD   = 12'h000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                PROG_WE,
    input  logic [ADDR_W-1:0]   PROG_ADDR,
    input  logic [INSTR_W-1:0]  PROG_DATA,
    input  logic                START,
    input  logic [ADDR_W:0]     PROG_LEN,
    output logic [INSTR_W-1:0]  CPU_IN,
    input  logic [RESULT_W-1:0] CPU_RESULT,
    input  logic                CPU_OVERFLOW,
    input  logic [ADDR_W-1:0]   RES_ADDR,
    output logic [RESULT_W:0]   RES_DATA,
    output logic                BUSY,
    output logic                DONE,
    output logic [ADDR_W:0]     OVF_COUNT,
    output logic                HALTED_OVF
);

    localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

    seq_state_t        state;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] idx;
    logic [HOLD_W-1:0] hold;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W:0]   ovf_cnt;
    logic              halted_q;

    logic [ADDR_W:0]   start_len;
    logic              capture;
    logic              last_word;
    logic              stop_early;
    logic              run_end;
    logic              prog_we_ok;
    logic [ADDR_W-1:0] prog_raddr;
    logic              prog_rclr;

    assign start_len  = (PROG_LEN > DEPTH_L) ? DEPTH_L : PROG_LEN;
    assign capture    = (state == RUN) && (hold == HOLD_LAST);
    assign last_word  = ({1'b0, idx} == (len - CNT_ONE));
    assign stop_early = STOP_ON_OVF && CPU_OVERFLOW;
    assign run_end    = capture && (last_word || stop_early);
    assign prog_we_ok = PROG_WE && (state == IDLE);

    // The program RAM read register is CPU_IN itself, so the address presented
    // here is the word that must be on the bus in the following cycle.
    always_comb begin
        prog_raddr = '0;
        prog_rclr  = 1'b1;
        case (state)
            IDLE: begin
                if (START && (start_len != '0)) begin
                    prog_rclr = 1'b0;
                end
            end
            RUN: begin
                if (!run_end) begin
                    prog_rclr  = 1'b0;
                    prog_raddr = capture ? (idx + IDX_ONE) : idx;
                end
            end
            default: begin
                prog_rclr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            len      <= '0;
            idx      <= '0;
            hold     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_cnt  <= '0;
            halted_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        len      <= start_len;
                        idx      <= '0;
                        hold     <= '0;
                        ovf_cnt  <= '0;
                        halted_q <= 1'b0;
                        if (start_len == '0) begin
                            state  <= FINISH;
                            done_q <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (capture) begin
                        if (CPU_OVERFLOW && (ovf_cnt < DEPTH_L)) begin
                            ovf_cnt <= ovf_cnt + CNT_ONE;
                        end
                        if (run_end) begin
                            state    <= FINISH;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            // An overflow on the final word is a normal completion.
                            halted_q <= stop_early && !last_word;
                        end else begin
                            idx  <= idx + IDX_ONE;
                            hold <= '0;
                        end
                    end else begin
                        hold <= hold + HOLD_ONE;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    minicpu_seq_ram #(
        .WIDTH   (INSTR_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .CLR_VAL (IDLE_WORD)
    ) u_prog_ram (
        .clk   (CLK),
        .rst   (RST),
        .we    (prog_we_ok),
        .waddr (PROG_ADDR),
        .wdata (PROG_DATA),
        .raddr (prog_raddr),
        .rclr  (prog_rclr),
        .rdata (CPU_IN)
    );

    minicpu_seq_ram #(
        .WIDTH   (RESULT_W + 1),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .CLR_VAL ('0)
    ) u_res_ram (
        .clk   (CLK),
        .rst   (RST),
        .we    (capture),
        .waddr (idx),
        .wdata ({CPU_OVERFLOW, CPU_RESULT}),
        .raddr (RES_ADDR),
        .rclr  (1'b0),
        .rdata (RES_DATA)
    );

    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign OVF_COUNT  = ovf_cnt;
    assign HALTED_OVF = halted_q;

endmodule

// File: tb/tb_minicpu_program_sequencer.sv
// Bench for minicpu_program_sequencer: two instances (free-running and stop-on-overflow)
// share all stimulus; a MiniCPU stub computes RESULT/OVERFLOW from the issued word.
module tb_minicpu_program_sequencer;
    import minicpu_pkg::*;

    localparam int          DEPTH  = 16;
    localparam int          ADDR_W = 4;
    localparam int          H      = 3;
    localparam logic [11:0] IDLE_W = 12'h000;

    logic        CLK;
    logic        RST;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [11:0] prog_data;
    logic        start;
    logic [4:0]  prog_len;
    logic [3:0]  res_addr;

    logic [11:0] a_cpu_in, b_cpu_in;
    logic [8:0]  a_fx, b_fx;
    logic [8:0]  a_res_data, b_res_data;
    logic        a_busy, b_busy, a_done, b_done, a_halted, b_halted;
    logic [4:0]  a_ovf_cnt, b_ovf_cnt;

    logic        sel;
    logic [11:0] cpu_in_s;
    logic [8:0]  res_data_s;
    logic        busy_s, done_s, halted_s;
    logic [4:0]  ovf_s;

    logic [11:0] model_prog [DEPTH];
    int          tests;
    int          fails;

    // MiniCPU stand-in: 9-bit sum of operand and opcode<<4; bit 8 is the overflow.
    function automatic logic [8:0] cpu_f(input logic [11:0] w);
        return {1'b0, w[7:0]} + {1'b0, w[11:8], 4'h0};
    endfunction

    assign a_fx = cpu_f(a_cpu_in);
    assign b_fx = cpu_f(b_cpu_in);

    assign cpu_in_s   = sel ? b_cpu_in   : a_cpu_in;
    assign res_data_s = sel ? b_res_data : a_res_data;
    assign busy_s     = sel ? b_busy     : a_busy;
    assign done_s     = sel ? b_done     : a_done;
    assign halted_s   = sel ? b_halted   : a_halted;
    assign ovf_s      = sel ? b_ovf_cnt  : a_ovf_cnt;

    minicpu_program_sequencer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD_CYCLES(H), .STOP_ON_OVF(1'b0), .IDLE_WORD(IDLE_W)
    ) u_dut_a (
        .CLK(CLK), .RST(RST), .PROG_WE(prog_we), .PROG_ADDR(prog_addr), .PROG_DATA(prog_data),
        .START(start), .PROG_LEN(prog_len), .CPU_IN(a_cpu_in), .CPU_RESULT(a_fx[7:0]),
        .CPU_OVERFLOW(a_fx[8]), .RES_ADDR(res_addr), .RES_DATA(a_res_data), .BUSY(a_busy),
        .DONE(a_done), .OVF_COUNT(a_ovf_cnt), .HALTED_OVF(a_halted)
    );

    minicpu_program_sequencer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD_CYCLES(H), .STOP_ON_OVF(1'b1), .IDLE_WORD(IDLE_W)
    ) u_dut_b (
        .CLK(CLK), .RST(RST), .PROG_WE(prog_we), .PROG_ADDR(prog_addr), .PROG_DATA(prog_data),
        .START(start), .PROG_LEN(prog_len), .CPU_IN(b_cpu_in), .CPU_RESULT(b_fx[7:0]),
        .CPU_OVERFLOW(b_fx[8]), .RES_ADDR(res_addr), .RES_DATA(b_res_data), .BUSY(b_busy),
        .DONE(b_done), .OVF_COUNT(b_ovf_cnt), .HALTED_OVF(b_halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic write_prog(input int a, input logic [11:0] d);
        prog_we   = 1'b1;
        prog_addr = 4'(a);
        prog_data = d;
        tick();
        prog_we   = 1'b0;
        model_prog[a] = d;
    endtask

    function automatic int exp_ovf(input int n);
        int          k;
        logic [8:0]  v;
        k = 0;
        for (int i = 0; i < n; i++) begin
            v = cpu_f(model_prog[i]);
            k += int'(v[8]);
        end
        return k;
    endfunction

    // Pulses START and watches the bus cycle by cycle against the expected schedule:
    // word i on the bus for cycles 1+i*H .. (i+1)*H, then the idle word.
    task automatic run(input int plen, input int words, input int exp_done, input bit inject,
                       input string tag);
        int          done_at, done_cnt, busy_cnt, in_err;
        logic [11:0] exp_in;
        done_at  = -1;
        done_cnt = 0;
        busy_cnt = 0;
        in_err   = 0;
        prog_len = 5'(plen);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int c = 1; c <= words * H + 4; c++) begin
            if (c > 1) tick();
            if (inject && c == 4) begin
                start = 1'b1; prog_we = 1'b1; prog_addr = 4'd1; prog_data = 12'hABC;
            end
            if (inject && c == 5) begin
                start = 1'b0; prog_we = 1'b0;
            end
            exp_in = (c <= words * H) ? model_prog[(c - 1) / H] : IDLE_W;
            if (cpu_in_s !== exp_in) in_err++;
            if (busy_s === 1'b1) busy_cnt++;
            if (done_s === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
        end
        check({tag, ".done_cycle"}, done_at, exp_done);
        check({tag, ".done_pulses"}, done_cnt, 1);
        check({tag, ".busy_cycles"}, busy_cnt, words * H);
        check({tag, ".cpu_in_errs"}, in_err, 0);
        for (int w = 0; w < 80 && (a_busy || b_busy || a_done || b_done); w++) tick();
        check({tag, ".settle"}, {a_busy, b_busy, a_done, b_done}, 0);
    endtask

    task automatic check_res(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            res_addr = 4'(i);
            tick();
            check($sformatf("%s.res[%0d]", tag, i), res_data_s, cpu_f(model_prog[i]));
        end
    endtask

    typedef struct {
        int plen;
        int words;
        int done_c;
    } vec_t;

    vec_t tbl [6];
    int   plen_r, words_r, dcnt;

    initial begin
        tests = 0; fails = 0; sel = 1'b0;
        RST = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; prog_len = '0; res_addr = '0;

        // PROG_LEN, words actually issued, DONE cycle relative to the START edge
        tbl[0] = '{5, 5, 16};
        tbl[1] = '{0, 0, 1};
        tbl[2] = '{31, 16, 49};
        tbl[3] = '{16, 16, 49};
        tbl[4] = '{1, 1, 4};
        tbl[5] = '{7, 7, 22};

        repeat (3) tick();
        check("reset.cpu_in", a_cpu_in, IDLE_W);
        check("reset.busy", a_busy, 0);
        check("reset.done", a_done, 0);
        check("reset.ovf_count", a_ovf_cnt, 0);
        check("reset.halted", a_halted, 0);
        check("reset.res_data", a_res_data, 0);
        RST = 1'b0;
        tick();

        write_prog(0, 12'h000); write_prog(1, 12'h100); write_prog(2, 12'h201);
        write_prog(3, 12'h300); write_prog(4, 12'h400);
        for (int i = 5; i < DEPTH; i++) write_prog(i, 12'((i << 8) | ((i * 17) & 255)));

        for (int t = 0; t < 6; t++) begin
            run(tbl[t].plen, tbl[t].words, tbl[t].done_c, 1'b0, $sformatf("tbl%0d", t));
            check($sformatf("tbl%0d.ovf_count", t), a_ovf_cnt, exp_ovf(tbl[t].words));
            check($sformatf("tbl%0d.halted", t), a_halted, 0);
            if (t == 0) check_res(5, "tbl0");
        end

        // START and PROG_WE pulsed mid-run must not disturb this run or the program
        run(5, 5, 16, 1'b1, "inject");
        run(5, 5, 16, 1'b0, "rerun");
        check_res(5, "rerun");

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) write_prog(i, 12'($urandom));
            plen_r  = $urandom_range(0, 31);
            words_r = (plen_r > DEPTH) ? DEPTH : plen_r;
            run(plen_r, words_r, words_r * H + 1, 1'b0, $sformatf("rnd%0d", r));
            check($sformatf("rnd%0d.ovf_count", r), a_ovf_cnt, exp_ovf(words_r));
            check($sformatf("rnd%0d.halted", r), a_halted, 0);
            check_res(words_r, $sformatf("rnd%0d", r));
        end

        // Stop-on-overflow instance: clean run first, then overflow on word 2
        sel = 1'b1;
        write_prog(0, 12'h000); write_prog(1, 12'h100); write_prog(2, 12'h201);
        write_prog(3, 12'h305); write_prog(4, 12'h400);
        run(5, 5, 16, 1'b0, "stop_pre");
        check("stop_pre.ovf_count", b_ovf_cnt, 0);
        check("stop_pre.halted", b_halted, 0);
        write_prog(2, 12'hF80); write_prog(3, 12'h3AA);
        run(5, 3, 10, 1'b0, "stop");
        check("stop.halted", b_halted, 1);
        check("stop.ovf_count", b_ovf_cnt, 1);
        check_res(3, "stop");
        check("stop.res2_value", b_res_data, 9'h170);
        res_addr = 4'd3;
        tick();
        check("stop.res3_kept", b_res_data, 9'h035);
        sel = 1'b0;

        // Reset during the 2nd cycle of word 1 aborts the run
        write_prog(0, 12'h0C3);
        prog_len = 5'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        RST = 1'b1;
        tick();
        check("abort.cpu_in", a_cpu_in, IDLE_W);
        check("abort.busy", a_busy, 0);
        RST = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (a_done === 1'b1) dcnt++;
            tick();
        end
        check("abort.no_done", dcnt, 0);
        res_addr = 4'd0;
        tick();
        check("abort.res0_kept", a_res_data, 9'h0C3);

        // START coincident with RST: reset wins
        RST = 1'b1; start = 1'b1; prog_len = 5'd5;
        tick();
        RST = 1'b0; start = 1'b0;
        check("rst_start.busy", a_busy, 0);
        tick();
        check("rst_start.busy_after", a_busy, 0);
        check("rst_start.cpu_in", a_cpu_in, IDLE_W);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/minicpu_program_sequencer.md
# minicpu_program_sequencer

Synthesizable instruction sequencer that drives the MiniCPU from the issuing side. It holds a small loadable program of 12-bit instruction words and presents them one at a time on the MiniCPU `IN` bus, holding each for a fixed number of clocks. On the last hold cycle it captures the MiniCPU `RESULT` and `OVERFLOW` into a readable result buffer. It replaces hand-timed stimulus with an on-chip, repeatable program run.

## Interface
- `DEPTH`, 16: program and result buffer entries.
- `ADDR_W`, 4: address width; `2**ADDR_W == DEPTH`.
- `HOLD_CYCLES`, 3: clocks each instruction is held on `CPU_IN`; must be ≥1.
- `STOP_ON_OVF`, 0: when 1, the run halts after the first captured overflow.
- `IDLE_WORD`, 12'h000: value of `CPU_IN` when not running.

Ports:
- `CLK  in  1`: clock; all logic on rising edge.
- `RST  in  1`: synchronous, active-high reset.
- `PROG_WE  in  1`: program write strobe.
- `PROG_ADDR  in  ADDR_W`: program write address.
- `PROG_DATA  in  12`: instruction word; [11:8] opcode, [7:0] operand field, passed opaquely.
- `START  in  1`: start-run pulse.
- `PROG_LEN  in  ADDR_W+1`: number of words to run; latched at start.
- `CPU_IN  out  12`: drives MiniCPU `IN`; registered.
- `CPU_RESULT  in  8`: from MiniCPU `RESULT`.
- `CPU_OVERFLOW  in  1`: from MiniCPU `OVERFLOW`.
- `RES_ADDR  in  ADDR_W`: result buffer read address.
- `RES_DATA  out  9`: `{ovf, result}` at `RES_ADDR`; registered, 1-cycle read latency.
- `BUSY  out  1`: run in progress.
- `DONE  out  1`: 1-cycle pulse when a run ends.
- `OVF_COUNT  out  ADDR_W+1`: overflows captured in the current or last run.
- `HALTED_OVF  out  1`: last run ended early due to `STOP_ON_OVF`.

## Operation
- FSM states: `IDLE`, `RUN`, `FINISH`.
- **IDLE**
  - `PROG_WE` writes `PROG_DATA` to `prog[PROG_ADDR]`.
  - On `START`:
    - latch `len = min(PROG_LEN, DEPTH)`;
    - clear `OVF_COUNT` and `HALTED_OVF`;
    - `idx=0`, `hold=0`.
  - If `len==0`, go to `FINISH`; otherwise go to `RUN`.
- **RUN**
  - `CPU_IN = prog[idx]`; `hold` counts `0..HOLD_CYCLES-1`.
  - Capture cycle (`hold==HOLD_CYCLES-1`):
    - write `{CPU_OVERFLOW, CPU_RESULT}` to `res[idx]`;
    - if `CPU_OVERFLOW`, increment `OVF_COUNT`.
  - After the capture cycle:
    - if `idx==len-1`, or `STOP_ON_OVF && CPU_OVERFLOW`, go to `FINISH`;
    - otherwise `idx++`, `hold=0`, and the next word appears with no gap.
  - `HALTED_OVF` is set only on the early-stop path.
- **FINISH**: `CPU_IN=IDLE_WORD`, `DONE=1` for one cycle, then go to `IDLE`.
- `START` outside `IDLE` is ignored.
- `PROG_WE` outside `IDLE` is dropped, so a running program is never modified.
- The result buffer is readable in any state; a read of the entry being captured returns the old value that cycle.
- `OVF_COUNT` saturates at `DEPTH`, which cannot be exceeded.

## Timing
- Reset values: `CPU_IN=IDLE_WORD`, `BUSY=0`, `DONE=0`, `OVF_COUNT=0`, `HALTED_OVF=0`, `RES_DATA=0`, FSM=`IDLE`.
- Program and result memories are not cleared by reset.
- `START` sampled at edge k:
  - `CPU_IN=prog[0]` and `BUSY=1` from cycle k+1;
  - word i is held for cycles k+1+i·H … k+i·H+H, where H=`HOLD_CYCLES`;
  - capture is at the end of each word's last cycle.
- After the final capture: `FINISH` lasts 1 cycle with `BUSY=0`, `DONE=1`, `CPU_IN=IDLE_WORD`.
- Full run of n words: `DONE` at cycle k+1+n·H.
- `len==0`: `DONE` at k+1, `CPU_IN` never leaves `IDLE_WORD`.
- `RST` mid-run aborts the run:
  - `CPU_IN=IDLE_WORD` next cycle;
  - no `DONE` pulse;
  - result entries already written are retained.
- `START` coincident with `RST`: reset wins.

## Structure
- Shared package `minicpu_pkg`:
  - `INSTR_W=12`, `RESULT_W=8`;
  - opcode field slice constants;
  - `seq_state_t` enum.
- One sub-module, `minicpu_seq_ram`: parameterized 1-write/1-read synchronous RAM.
  - Instantiated twice: program (width 12), result (width 9).
- Top level holds the FSM, hold/index counters and the overflow counter.

## Test plan
- Load `000,100,201,300,400` (hex), `PROG_LEN=5`, H=3, MiniCPU model attached → `CPU_IN` shows each word for exactly 3 cycles; `DONE` at k+16; `RES_DATA[0..4]` match the model's outputs.
- `PROG_LEN=0` → `DONE` at k+1; `BUSY` never high; `CPU_IN` stays `000`.
- `STOP_ON_OVF=1`, overflow forced on word 2 of 5 → `HALTED_OVF=1`, `OVF_COUNT=1`, `DONE` at k+1+3·3, `res[3]` unchanged.
- `PROG_LEN=31`, `DEPTH=16` → exactly 16 words issued; `DONE` at k+49.
- `START` and `PROG_WE` pulsed mid-run → neither the run nor the program is altered; a following run reproduces the same results.
- `RST` asserted at the 2nd cycle of word 1 → next cycle `CPU_IN=000`, `BUSY=0`, no `DONE`; `res[0]` is still readable.
